// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI bus bundle between a master and the slave memory responder
interface axi_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI slave register-array memory with independent FIXED/INCR write and read burst engines
module axi_slave_mem #(
  parameter int               ID_W      = 4,
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic               aclk,
  input logic               aresetn,
  axi_slave_mem_if.slave    bus
);
  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a >= BASE_ADDR && ((a - BASE_ADDR) >> LG) < ADDR_W'(DEPTH);
  endfunction
  function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
    return IW'((a - BASE_ADDR) >> LG);
  endfunction
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || size > 3'(LG);
  endfunction
  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a, input logic [1:0] burst, input logic [2:0] size);
    return burst == 2'b01 ? a + (ADDR_W'(1) << size) : a;
  endfunction
  // Holds both ready outputs low during reset and raises them the cycle after release
  logic live;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) live <= 1'b0;
    else live <= 1'b1;
  w_state_t          w_st, w_nx;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              aw_hs, w_beat, w_end, w_ok;
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_beat = bus.wvalid && w_st == W_DATA;
  assign w_end  = w_cnt == w_len;
  assign w_ok   = in_range(w_addr) && !burst_bad(w_burst, w_size);
  assign bus.awready = live && w_st == W_IDLE;
  assign bus.wready  = w_st == W_DATA;
  assign bus.bvalid  = w_st == W_RESP;
  assign bus.bid     = w_id;
  assign bus.bresp   = {w_err, 1'b0};
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) w_st <= W_IDLE;
    else w_st <= w_nx;
  always_comb begin
    w_nx = w_st;
    if (aw_hs) w_nx = W_DATA;
    else if (w_beat && w_end) w_nx = W_RESP;
    else if (bus.bvalid && bus.bready) w_nx = W_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= bus.awid;
      w_addr  <= bus.awaddr;
      w_len   <= bus.awlen;
      w_cnt   <= '0;
      w_size  <= bus.awsize;
      w_burst <= bus.awburst;
      w_err   <= 1'b0;
    end else if (w_beat) begin
      w_cnt  <= w_cnt + 4'd1;
      w_addr <= step(w_addr, w_burst, w_size);
      w_err  <= w_err || !w_ok || (bus.wlast != w_end);
    end
  always_ff @(posedge aclk)
    if (w_beat && w_ok)
      for (int b = 0; b < NB; b++)
        if (bus.wstrb[b]) mem[widx(w_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
  r_state_t          r_st, r_nx;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_next;
  logic [3:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst, r_resp;
  logic [DATA_W-1:0] r_data;
  logic              ar_hs, r_hs, r_end, ar_ok, nx_ok;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign r_hs   = bus.rvalid && bus.rready;
  assign r_end  = r_cnt == r_len;
  assign r_next = step(r_addr, r_burst, r_size);
  assign ar_ok  = in_range(bus.araddr) && !burst_bad(bus.arburst, bus.arsize);
  assign nx_ok  = in_range(r_next) && !burst_bad(r_burst, r_size);
  assign bus.arready = live && r_st == R_IDLE;
  assign bus.rvalid  = r_st == R_DATA;
  assign bus.rid     = r_id;
  assign bus.rdata   = r_data;
  assign bus.rresp   = r_resp;
  assign bus.rlast   = bus.rvalid && r_end;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_st <= R_IDLE;
    else r_st <= r_nx;
  always_comb begin
    r_nx = r_st;
    if (ar_hs) r_nx = R_DATA;
    else if (r_hs && r_end) r_nx = R_IDLE;
  end
  // Next beat is fetched on the handshake edge so RREADY held high gives one beat per cycle
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_resp  <= '0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= bus.arid;
      r_addr  <= bus.araddr;
      r_len   <= bus.arlen;
      r_cnt   <= '0;
      r_size  <= bus.arsize;
      r_burst <= bus.arburst;
      r_resp  <= ar_ok ? 2'b00 : 2'b10;
      r_data  <= ar_ok ? mem[widx(bus.araddr)] : '0;
    end else if (r_hs && !r_end) begin
      r_cnt  <= r_cnt + 4'd1;
      r_addr <= r_next;
      r_resp <= nx_ok ? 2'b00 : 2'b10;
      r_data <= nx_ok ? mem[widx(r_next)] : '0;
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bus transactions against axi_slave_mem with hand-computed expectations
module tb_axi_slave_mem;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  axi_slave_mem_if bus ();
  axi_slave_mem dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [31:0] wdat [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid0, bid_o;
  logic [1:0]  bresp_o;
  logic        lat;
  int          gaps;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? bus.awready : w == 1 ? bus.wready : w == 2 ? bus.bvalid : w == 3 ? bus.arready : bus.rvalid;
  endfunction
  task automatic wait_for(input int w, input string tag, output int n);
    n = 0;
    while (!sig(w) && n < 64) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 64) check({tag, "_timeout"}, 0, 1);
  endtask
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb, input int bad);
    int n;
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    wait_for(0, "aw", n);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1; bus.wdata = wdat[i]; bus.wstrb = strb;
      bus.wlast = (i == int'(len)) != (i == bad);
      wait_for(1, "w", n);
      @(negedge aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    wait_for(2, "b", n);
    bresp_o = bus.bresp; bid_o = bus.bid;
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall);
    int n;
    @(negedge aclk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    wait_for(3, "ar", n);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    lat = bus.rvalid;
    gaps = 0;
    bus.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      wait_for(4, "r", n);
      gaps += n;
      rd[i] = bus.rdata; rr[i] = bus.rresp; rl[i] = bus.rlast;
      if (i == 0) rid0 = bus.rid;
      if (i == stall) begin
        bus.rready = 1'b0;
        repeat (2) begin
          @(negedge aclk);
          check("hold_valid", bus.rvalid, 1);
          check("hold_data", bus.rdata, rd[i]);
          check("hold_last", bus.rlast, rl[i]);
        end
        bus.rready = 1'b1;
      end
      @(negedge aclk);
    end
    bus.rready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    repeat (3) @(negedge aclk);
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", bus.awready, 1);
    check("rel_arready", bus.arready, 1);
    wdat[0] = 32'hDEADBEEF;
    do_write(3, 32'h10, 0, 2, 2'b01, 4'hF, -1);
    check("t1_bresp", bresp_o, 0);
    check("t1_bid", bid_o, 3);
    do_read(3, 32'h10, 0, 2, 2'b01, -1);
    check("t1_latency", lat, 1);
    check("t1_rid", rid0, 3);
    check("t1_rdata", rd[0], 32'hDEADBEEF);
    check("t1_rresp", rr[0], 0);
    check("t1_rlast", rl[0], 1);
    for (int i = 0; i < 4; i++) wdat[i] = i + 1;
    do_write(1, 32'h20, 3, 2, 2'b01, 4'hF, -1);
    check("t2_bresp", bresp_o, 0);
    do_read(2, 32'h20, 3, 2, 2'b01, -1);
    for (int i = 0; i < 4; i++) begin
      check("t2_rdata", rd[i], i + 1);
      check("t2_rlast", rl[i], i == 3);
    end
    check("t2_gaps", gaps, 0);
    wdat[0] = 32'hAABBCCDD;
    do_write(4, 32'h20, 0, 2, 2'b01, 4'b0101, -1);
    do_read(5, 32'h20, 3, 2, 2'b01, 1);
    check("t3_strb", rd[0], 32'h00BB00DD);
    check("t3_b1", rd[1], 2);
    check("t3_b2", rd[2], 3);
    check("t3_b3", rd[3], 4);
    check("t3_last", rl[3], 1);
    wdat[0] = 7; wdat[1] = 8; wdat[2] = 9;
    do_write(6, 32'h40, 2, 2, 2'b00, 4'hF, -1);
    check("t4_fixed_bresp", bresp_o, 0);
    do_read(6, 32'h40, 0, 2, 2'b01, -1);
    check("t4_fixed_rdata", rd[0], 9);
    wdat[0] = 32'h55;
    do_write(7, 32'h40, 0, 2, 2'b10, 4'hF, -1);
    check("t4_wrap_bresp", bresp_o, 2);
    do_read(7, 32'h40, 0, 2, 2'b01, -1);
    check("t4_wrap_unchanged", rd[0], 9);
    do_read(8, 32'h40, 1, 2, 2'b10, -1);
    check("t4_arwrap_resp0", rr[0], 2);
    check("t4_arwrap_resp1", rr[1], 2);
    check("t4_arwrap_data0", rd[0], 0);
    check("t4_arwrap_data1", rd[1], 0);
    check("t4_arwrap_last", rl[1], 1);
    do_write(9, 32'h40, 0, 3, 2'b01, 4'hF, -1);
    check("t4_size_bresp", bresp_o, 2);
    wdat[0] = 32'h11; wdat[1] = 32'h22;
    do_write(1, 32'h3FC, 1, 2, 2'b01, 4'hF, -1);
    check("t5_oor_bresp", bresp_o, 2);
    do_read(1, 32'h3FC, 1, 2, 2'b01, -1);
    check("t5_oor_data0", rd[0], 32'h11);
    check("t5_oor_resp0", rr[0], 0);
    check("t5_oor_data1", rd[1], 0);
    check("t5_oor_resp1", rr[1], 2);
    wdat[0] = 5; wdat[1] = 6;
    do_write(2, 32'h80, 1, 2, 2'b01, 4'hF, 0);
    check("t5_wlast_bresp", bresp_o, 2);
    do_read(2, 32'h80, 1, 2, 2'b01, -1);
    check("t5_wlast_data0", rd[0], 5);
    check("t5_wlast_data1", rd[1], 6);
    @(negedge aclk);
    bus.arid = 4'hA; bus.araddr = 32'h20; bus.arlen = 3; bus.arsize = 2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    wait_for(3, "t6_ar", n);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (2) @(negedge aclk);
    check("t6_pre_rst_data", bus.rdata, 3);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_rvalid", bus.rvalid, 0);
    check("t6_rst_rdata", bus.rdata, 0);
    check("t6_rst_rid", bus.rid, 0);
    check("t6_rst_rlast", bus.rlast, 0);
    check("t6_rst_arready", bus.arready, 0);
    check("t6_rst_awready", bus.awready, 0);
    bus.rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("t6_rel_arready", bus.arready, 1);
    check("t6_rel_awready", bus.awready, 1);
    check("t6_rel_rvalid", bus.rvalid, 0);
    wdat[0] = 32'hA; wdat[1] = 32'hB;
    do_write(3, 32'h100, 1, 2, 2'b01, 4'hF, -1);
    check("t6_bresp", bresp_o, 0);
    check("t6_bid", bid_o, 3);
    do_read(3, 32'h100, 1, 2, 2'b01, -1);
    check("t6_data0", rd[0], 32'hA);
    check("t6_data1", rd[1], 32'hB);
    check("t6_last", rl[1], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI slave responder: a word-addressed register-array memory that sits on the slave end of the team's AXI interface.
- Serves as the default target for master-side blocks and for bus tests.
- Implements independent write and read burst engines supporting FIXED and INCR bursts with 4-bit LEN (up to 16 beats).
- Returns OKAY/SLVERR responses with the requesting ID.

Parameters:
- ID_W, 4, width of AWID/BID/ARID/RID
- ADDR_W, 32, byte address width
- DATA_W, 32, data bus width; must be 32 or 64
- DEPTH, 256, memory size in DATA_W words
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_W/8

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/4/3/2  write address payload
- AWVALID  in  1 ; AWREADY  out  1  write address handshake
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data payload
- WVALID  in  1 ; WREADY  out  1  write data handshake
- BID/BRESP  out  ID_W/2  write response payload
- BVALID  out  1 ; BREADY  in  1  write response handshake
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/4/3/2  read address payload
- ARVALID  in  1 ; ARREADY  out  1  read address handshake
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data payload
- RVALID  out  1 ; RREADY  in  1  read data handshake

Behaviour:

Reset
- While ARESETn=0, all outputs are 0 and both FSMs are in IDLE.
- AWREADY and ARREADY rise in the first cycle after reset release.
- Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No response is issued, and beats already written stay written.

Beat address arithmetic
- Beat address: addr_n = addr + n*(1<<SIZE) for INCR; addr_0 for FIXED.
- Word index = (addr_n - BASE_ADDR) >> log2(DATA_W/8).
- A beat is out of range if addr_n < BASE_ADDR or index >= DEPTH.
- Address arithmetic is ADDR_W wide and wraps silently; the range check catches the result.

Burst error rules
- Burst is in error if BURST is WRAP or reserved (2'b10/2'b11), or if (1<<SIZE) > DATA_W/8.
- An errored burst transfers no memory data but still completes all LEN+1 beats.

Write FSM: W_IDLE -> W_DATA -> W_RESP
- W_IDLE: AWREADY=1. On AWVALID, capture ID, addr, LEN, SIZE, BURST, clear beat counter and err flag, go to W_DATA.
- W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the bytes whose WSTRB bit is set, unless the beat is out of range or the burst is in error.
- The err flag sets on an out-of-range beat, an errored burst, or a WLAST value that differs from (counter==LEN).
- Termination is by counter only: after beat LEN, go to W_RESP.
- W_RESP: BVALID=1, BID=captured ID, BRESP = err ? 2'b10 : 2'b00. Hold until BREADY, then W_IDLE.
- Back-to-back bursts: minimum one W_IDLE cycle between bursts.

Read FSM: R_IDLE -> R_DATA
- R_IDLE: ARREADY=1. On ARVALID, capture the request, register RDATA = mem[word(addr_0)] (0 if out of range or errored), go to R_DATA.
- RVALID rises the cycle after the AR handshake (1-cycle latency).
- R_DATA: RVALID=1, RID=captured ID, RLAST=(counter==LEN). RRESP=2'b10 for an out-of-range beat or errored burst, else 2'b00.
- RID/RDATA/RRESP/RLAST are stable while RVALID && !RREADY.
- On RVALID&&RREADY with counter<LEN, increment counter and load the next beat's data in the same edge, giving full throughput of 1 beat/cycle.
- On the handshake of the RLAST beat, go to R_IDLE.

Concurrency
- The write and read channels run independently and concurrently.
- A read-beat load and a write to the same word on the same edge: the read returns the old data.

Test Plan:
- Single write then read: AW{id=3, addr=0x10, len=0, size=2, INCR}, W{0xDEADBEEF, strb=F, last=1} -> B{id=3, OKAY}; AR same address -> R{id=3, 0xDEADBEEF, OKAY, last=1}, with RVALID one cycle after the AR handshake.
- INCR burst: write len=3 at 0x20 with data 1,2,3,4 -> one B OKAY; read len=3 with RREADY held high -> 4 consecutive beats 1,2,3,4, RLAST only on beat 4.
- Strobes and backpressure: overwrite 0x20 with 0xAABBCCDD, strb=4'b0101 -> read returns 0x00BB00DD. Toggle RREADY low for 2 cycles mid-burst -> payload held, no beat lost.
- FIXED burst len=2 to 0x40 with data 7,8,9 -> read 0x40 returns 9. WRAP burst -> BRESP=SLVERR and memory unchanged; AR WRAP len=1 -> 2 beats with RRESP=SLVERR, RDATA=0.
- Out of range and WLAST error: write at BASE_ADDR+DEPTH*4-4 with len=1 -> beat 2 dropped, BRESP=SLVERR. WLAST on beat 0 of a len=1 burst -> burst still takes 2 beats, BRESP=SLVERR.
- Reset mid-burst: assert ARESETn=0 during beat 2 of a read burst -> all outputs 0 asynchronously; after release ARREADY=1 and AWREADY=1, and a new burst completes normally.
